rotl_pipe: RTL and testbench

- Pipelined 32-bit rotate-left unit: the left-direction counterpart of the combinational right rotator used in the miner datapath.
- Accepts one word plus a rotate amount per cycle over a valid/ready handshake.
- Has one registered log-shifter stage per amount bit; each stage is elastic, so backpressure stalls only what is needed.
- Sits between the message-schedule word source and the consumers that need left-rotated words, for example inverse checking of rotated words against a model.

---
 rtl/rot_pkg.sv | 28 ++
 rtl/rotl_stage.sv | 68 ++++++
 rtl/rotl_pipe.sv | 91 +++++++++
 tb/tb_rotl_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
`default_nettype none
//==============================================================================
// Module : rot_pkg
// Brief  : Shared word/amount widths and constant-rotate helper for rotators.
// Rev    : 1.0 - initial release
//==============================================================================
package rot_pkg;

    localparam int WORD_W = 32;
    localparam int ROT_W  = 5;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [ROT_W-1:0]  sel;
    } rot_req_t;

    // Upper half of {word,word} << n is the word rotated left by n.
    function automatic logic [WORD_W-1:0] rotl_const(
        input logic [WORD_W-1:0] word,
        input int unsigned       amount
    );
        logic [2*WORD_W-1:0] w_dbl;
        w_dbl = {word, word} << (amount % WORD_W);
        return w_dbl[2*WORD_W-1:WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotl_stage.sv
`default_nettype none
//==============================================================================
// Module : rotl_stage
// Brief  : One elastic log-shifter stage; applies the low amount bit it receives.
// Rev    : 1.0 - initial release
//==============================================================================
module rotl_stage
    import rot_pkg::*;
#(
    parameter int          WIDTH = WORD_W,
    parameter int unsigned SHIFT = 1,
    parameter int          SELW  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WIDTH+SELW:0]   i_bus,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WIDTH+SELW-1:0] o_bus
);

    // Bus layout: {data, remaining amount bits, this stage's amount bit}.
    logic                  r_valid;
    logic [WIDTH+SELW-1:0] r_bus;
    logic [WIDTH-1:0]      w_word;
    logic [WIDTH-1:0]      w_rot;
    logic [WIDTH+SELW-1:0] w_next;
    logic                  w_ready;

    assign w_word = i_bus[WIDTH+SELW -: WIDTH];

    generate
        if (WIDTH == WORD_W) begin : g_pkg_rot
            assign w_rot = rotl_const(w_word, SHIFT);
        end else begin : g_cat_rot
            assign w_rot = {w_word[WIDTH-SHIFT-1:0], w_word[WIDTH-1:WIDTH-SHIFT]};
        end
    endgenerate

    always_comb begin
        w_next = i_bus[WIDTH+SELW:1];
        if (i_bus[0]) begin
            w_next[SELW +: WIDTH] = w_rot;
        end
    end

    assign w_ready = ~r_valid | i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else if (i_valid && w_ready) begin
            r_valid <= 1'b1;
            r_bus   <= w_next;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_bus   = r_bus;

endmodule
`default_nettype wire

// File: rtl/rotl_pipe.sv
`default_nettype none
//==============================================================================
// Module : rotl_pipe
// Brief  : Pipelined rotate-left, one elastic stage per amount bit, FIFO order.
// Rev    : 1.0 - initial release
//==============================================================================
module rotl_pipe
    import rot_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SHW   = ROT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [SHW:0]     occupancy
);

    localparam logic [SHW:0] c_occ_one = (SHW+1)'(1);

    logic [SHW-1:0] w_valid;
    logic [SHW:0]   w_ready;
    logic           w_in_acc;
    logic           w_out_acc;
    logic [SHW:0]   r_occ;

    assign w_ready[SHW] = out_ready;

    // Each stage hands its payload, one amount bit shorter, to the next.
    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            logic [WIDTH+SHW-k-1:0] w_in;
            logic [WIDTH+SHW-k-2:0] w_out;
            logic                   w_up_valid;

            if (k == 0) begin : g_head
                assign w_in       = {in_data, in_sel};
                assign w_up_valid = in_valid;
            end else begin : g_body
                assign w_in       = g_stage[k-1].w_out;
                assign w_up_valid = w_valid[k-1];
            end

            rotl_stage #(
                .WIDTH (WIDTH),
                .SHIFT (1 << k),
                .SELW  (SHW - k - 1)
            ) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .i_valid (w_up_valid),
                .o_ready (w_ready[k]),
                .i_bus   (w_in),
                .o_valid (w_valid[k]),
                .i_ready (w_ready[k+1]),
                .o_bus   (w_out)
            );
        end
    endgenerate

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[SHW-1];
    assign out_data  = g_stage[SHW-1].w_out;

    assign w_in_acc  = in_valid & w_ready[0];
    assign w_out_acc = w_valid[SHW-1] & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ <= '0;
        end else begin
            case ({w_in_acc, w_out_acc})
                2'b10:   r_occ <= r_occ + c_occ_one;
                2'b01:   r_occ <= r_occ - c_occ_one;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occupancy = r_occ;
    assign busy      = (r_occ != '0);

endmodule
`default_nettype wire

// File: tb/tb_rotl_pipe.sv
`default_nettype none
//==============================================================================
// Module : tb_rotl_pipe
// Brief  : Scoreboard bench for rotl_pipe: directed, stall, reset and random runs.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_rotl_pipe;
    import rot_pkg::*;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] in_data   = '0;
    logic [4:0]  in_sel    = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;
    logic [5:0]  occupancy;

    rotl_pipe #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] orig;
        logic [4:0]  sel;
        int          cyc;
        bit          lat;
        bit          rt;
    } sb_t;

    sb_t         sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data = '0;
    bit          rnd_done  = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] rotl_ref(input logic [31:0] d, input int s);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[(i + s) % 32] = d[i];
        return r;
    endfunction

    function automatic logic [31:0] rotr_ref(input logic [31:0] d, input int s);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = d[(i + s) % 32];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                if (out_valid) check("hold_data", {32'd0, out_data}, {32'd0, hold_data});
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h with empty scoreboard", out_data);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", {32'd0, out_data}, {32'd0, e.exp});
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd5);
                    if (e.rt)  check("round_trip", {32'd0, rotr_ref(out_data, int'(e.sel))}, {32'd0, e.orig});
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic [4:0] s, input logic [31:0] e,
                            input bit lat, input bit rt);
        sb_t it;
        it.exp = e; it.orig = d; it.sel = s; it.cyc = cyc; it.lat = lat; it.rt = rt;
        sbq.push_back(it);
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [31:0] e,
                        input bit lat, input bit rt);
        int n = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        while (!ok && n <= 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) push_exp(d, s, e, lat, rt);
        else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((occupancy != 0 || sbq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", {63'd0, (n < budget)}, 64'd1);
        @(posedge clk); #1;
    endtask

    logic [31:0] d_tab[6];
    logic [4:0]  s_tab[6];
    logic [31:0] e_tab[6];

    initial begin
        int acc;
        int idx;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data",  {32'd0, out_data},  64'd0);
        check("rst_occupancy", {58'd0, occupancy}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_busy",      {63'd0, busy},      64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_in_ready",  {63'd0, in_ready},  64'd1);
        @(posedge clk); #1;

        // Isolated words, latency checked
        send(32'h80000001, 5'd1,  32'h00000003, 1'b1, 1'b0); wait_drain(50);
        send(32'h12345678, 5'd4,  32'h23456781, 1'b1, 1'b0); wait_drain(50);
        send(32'h12345678, 5'd16, 32'h56781234, 1'b1, 1'b0); wait_drain(50);
        send(32'h00000001, 5'd31, 32'h80000000, 1'b1, 1'b0); wait_drain(50);
        send(32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b1, 1'b0); wait_drain(50);

        // Back-to-back stream over every amount
        for (int s = 0; s < 32; s++)
            send(32'hA5A5000F, 5'(s), rotl_ref(32'hA5A5000F, s), 1'b1, 1'b0);
        wait_drain(100);

        // Backpressure fill, then simultaneous in/out on a full pipe
        d_tab = '{32'h0000FFFF, 32'hF0000000, 32'h00000003, 32'h12345678, 32'h87654321, 32'hCAFEBABE};
        s_tab = '{5'd8, 5'd4, 5'd30, 5'd8, 5'd12, 5'd16};
        e_tab = '{32'h00FFFF00, 32'h0000000F, 32'hC0000000, 32'h34567812, 32'h54321876, 32'hBABECAFE};
        acc = 0;
        idx = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d_tab[0];
        in_sel    = s_tab[0];
        for (int c = 0; c < 12; c++) begin
            if (c == 2) out_ready = 1'b0;
            @(negedge clk);
            if (in_ready && idx < 5) begin
                push_exp(d_tab[idx], s_tab[idx], e_tab[idx], 1'b0, 1'b0);
                acc++;
                idx++;
            end
            @(posedge clk); #1;
            in_data = d_tab[idx];
            in_sel  = s_tab[idx];
        end
        @(negedge clk);
        check("bp_accepts",   64'(acc),             64'd5);
        check("bp_occupancy", {58'd0, occupancy},   64'd5);
        check("bp_in_ready",  {63'd0, in_ready},    64'd0);
        check("bp_busy",      {63'd0, busy},        64'd1);
        check("bp_out_valid", {63'd0, out_valid},   64'd1);
        check("bp_out_data",  {32'd0, out_data},    {32'd0, e_tab[0]});
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("sim_in_ready", {63'd0, in_ready}, 64'd1);
        if (in_ready) push_exp(d_tab[5], s_tab[5], e_tab[5], 1'b0, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("sim_occupancy", {58'd0, occupancy}, 64'd5);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain(50);

        // Gapped input against a stalled output compresses to a full pipe
        out_ready = 1'b0;
        send(32'h00000001, 5'd1,  32'h00000002, 1'b0, 1'b0); idle(2);
        send(32'h40000000, 5'd2,  32'h00000001, 1'b0, 1'b0); idle(3);
        send(32'h0F0F0F0F, 5'd4,  32'hF0F0F0F0, 1'b0, 1'b0); idle(1);
        send(32'h00FF0000, 5'd24, 32'h0000FF00, 1'b0, 1'b0); idle(2);
        send(32'hAAAAAAAA, 5'd1,  32'h55555555, 1'b0, 1'b0); idle(2);
        @(negedge clk);
        check("bub_occupancy", {58'd0, occupancy}, 64'd5);
        check("bub_in_ready",  {63'd0, in_ready},  64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain(50);

        // Reset with words in flight discards them
        send(32'h11111111, 5'd3, 32'h88888888, 1'b0, 1'b0);
        send(32'h22222222, 5'd5, 32'h44444444, 1'b0, 1'b0);
        send(32'h33333333, 5'd7, 32'h99999999, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_occupancy", {58'd0, occupancy}, 64'd0);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_busy",      {63'd0, busy},      64'd0);
        check("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
        sbq.delete();
        idle(2);
        reset_n = 1'b1;
        idle(10);
        @(negedge clk);
        check("post_mid_rst_occupancy", {58'd0, occupancy}, 64'd0);
        @(posedge clk); #1;

        // Random valid/ready traffic with model and round-trip checks
        fork
            begin
                for (int i = 0; i < 4000; i++) begin
                    logic [31:0] d;
                    logic [4:0]  s;
                    d = $urandom;
                    s = 5'($urandom_range(0, 31));
                    send(d, s, rotl_ref(d, int'(s)), 1'b0, 1'b1);
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(200);
        check("sb_empty", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
